// File: rtl/imem_loader.sv
// Instruction-memory loader: streams len words from a valid/ready source into
// a 32-entry imem, keeps a running XOR checksum, then releases the fetch unit.
module imem_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  len,
    input  logic        in_valid,
    input  logic [12:0] in_data,
    output logic        in_ready,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [12:0] wdata,
    output logic        cpu_ce,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [12:0] csum
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  len_q;
    logic [4:0]  cnt;
    logic        len_ok;
    logic        start_req;
    logic        accept;
    logic        last_word;

    assign len_ok    = (len != 6'd0) && (len <= 6'd32);
    assign start_req = start && (state != LOAD);
    assign accept    = in_valid && (state == LOAD);
    // len_q is 1..32 during LOAD, so len_q-1 fits the 5-bit counter range.
    assign last_word = accept && ({1'b0, cnt} == (len_q - 6'd1));

    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);
    assign cpu_ce   = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next-state defaults to the current state before the case so no
    // path leaves state_nxt unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_req) state_nxt = len_ok ? LOAD : IDLE;
            LOAD:       if (last_word) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q   <= '0;
            cnt     <= '0;
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            cpu_rst <= 1'b0;
            err     <= 1'b0;
            csum    <= '0;
        end else begin
            we      <= accept;
            cpu_rst <= last_word;
            if (start_req) begin
                if (len_ok) begin
                    len_q <= len;
                    cnt   <= '0;
                    csum  <= '0;
                    err   <= 1'b0;
                end else begin
                    err   <= 1'b1;
                end
            end
            if (accept) begin
                waddr <= cnt;
                wdata <= in_data;
                csum  <= csum ^ in_data;
                // Hold on the final word so a 32-word load never wraps to 0.
                if (!last_word) cnt <= cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go into a scoreboard queue
// and a negedge monitor pops and compares every we pulse, including its cycle.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  len;
    logic        in_valid;
    logic [12:0] in_data;
    logic        in_ready, we, cpu_ce, cpu_rst, busy, done, err;
    logic [4:0]  waddr;
    logic [12:0] wdata, csum;

    typedef struct {
        logic [4:0]  addr;
        logic [12:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          widx = 0;
    logic [12:0] exp_csum = '0;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .cpu_ce(cpu_ce),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err), .csum(csum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every we pulse must match the oldest expected write and cycle.
    always @(negedge clk) begin
        if (reset === 1'b1 && we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", we, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("waddr", waddr, e.addr);
                check("wdata", wdata, e.data);
                check("we_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start(input logic [5:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one beat; when valid, the bench expects it accepted on the next
    // edge and written one cycle later.
    task automatic send(input logic [12:0] d, input bit v);
        in_valid = v;
        in_data  = d;
        if (v) begin
            exp_q.push_back('{addr: widx[4:0], data: d, cyc: cyc + 1});
            widx++;
            exp_csum ^= d;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic new_load();
        widx     = 0;
        exp_csum = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready, 0);
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_cpu_ce", cpu_ce, 0);
        check("rst_cpu_rst", cpu_rst, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_csum", csum, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        #3;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);

        // Basic load: 0x0001 ^ 0x0A5A ^ 0x1FFF = 0x15A4.
        do_start(6'd3);
        new_load();
        check("load_busy", busy, 1);
        check("load_in_ready", in_ready, 1);
        send(13'h0001, 1'b1);
        send(13'h0A5A, 1'b1);
        send(13'h1FFF, 1'b1);
        check("basic_done", done, 1);
        check("basic_cpu_ce", cpu_ce, 1);
        check("basic_cpu_rst", cpu_rst, 1);
        check("basic_in_ready", in_ready, 0);
        check("basic_csum", csum, 13'h15A4);
        @(negedge clk);
        check("basic_cpu_rst_pulse", cpu_rst, 0);
        check("basic_done_hold", done, 1);

        // Reload from DONE, with a start pulse during LOAD that must be ignored.
        do_start(6'd2);
        new_load();
        check("reload_cpu_ce", cpu_ce, 0);
        check("reload_done", done, 0);
        check("reload_csum_clr", csum, 0);
        start = 1'b1; len = 6'd5;
        send(13'h0111, 1'b1);
        start = 1'b0;
        send(13'h0222, 1'b1);
        check("reload_done2", done, 1);
        check("reload_csum", csum, exp_csum);

        // Bad lengths from DONE and from IDLE.
        do_start(6'd0);
        check("len0_err", err, 1);
        check("len0_in_ready", in_ready, 0);
        check("len0_cpu_ce", cpu_ce, 0);
        send(13'h0055, 1'b0);
        do_start(6'd33);
        check("len33_err", err, 1);
        check("len33_busy", busy, 0);
        check("len33_in_ready", in_ready, 0);

        // Throttled source: valid pattern 1,0,0,1.
        do_start(6'd2);
        new_load();
        check("thr_err_clr", err, 0);
        send(13'h1234, 1'b1);
        send(13'h0777, 1'b0);
        send(13'h0888, 1'b0);
        check("thr_still_loading", busy, 1);
        send(13'h0BCD, 1'b1);
        check("thr_done", done, 1);
        check("thr_csum", csum, exp_csum);

        // Full depth: 32 words equal to their index, valid held two extra beats.
        do_start(6'd32);
        new_load();
        for (int i = 0; i < 32; i++) send(13'(i), 1'b1);
        check("full_last_addr", waddr, 31);
        check("full_in_ready", in_ready, 0);
        check("full_done", done, 1);
        check("full_csum", csum, exp_csum);
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("full_no_wrap", done, 1);

        // Reset mid-load after four accepts.
        do_start(6'd8);
        new_load();
        for (int i = 0; i < 4; i++) send(13'h0100 + 13'(i), 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        check("rst_hold_we", we, 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_done", done, 0);
        do_start(6'd1);
        new_load();
        send(13'h0123, 1'b1);
        check("post_rst_csum", csum, 13'h0123);
        check("post_rst_done2", done, 1);
        check("post_rst_cpu_rst", cpu_rst, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have the following ports, as name, direction, width and meaning:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; low clears all state at once.
- start  in  1  request a new program load; sampled on clk.
- len  in  6  word count for the load (1..32); sampled when start is accepted.
- in_valid  in  1  source presents a word on in_data.
- in_data  in  13  instruction word from the source.
- in_ready  out  1  loader accepts a word this cycle.
- we  out  1  instruction-memory write strobe.
- waddr  out  5  instruction-memory write address.
- wdata  out  13  instruction-memory write data.
- cpu_ce  out  1  fetch-unit clock enable; high only when a program is loaded.
- cpu_rst  out  1  one-cycle fetch-unit PC restart pulse.
- busy  out  1  load in progress.
- done  out  1  last load completed.
- err  out  1  last start request was rejected (bad len).
- csum  out  13  XOR of all words accepted in the current or last load.

Function
REQ-003 The FSM SHALL have three states: IDLE, LOAD and DONE; IDLE is the reset state.
REQ-004 The block SHALL accept start when start=1 in IDLE or DONE.
- If 1<=len<=32: go to LOAD; latch len; clear the word counter, csum and err; drop done.
- Otherwise: stay or return to IDLE and set err=1.
REQ-005 The block SHALL ignore start while in LOAD.
REQ-006 in_ready SHALL be 1 exactly when the state is LOAD (decoded from state, no extra latency).
REQ-007 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL have no effect.
REQ-008 For an accepted word k (0-based), the block SHALL drive we=1, waddr=k and wdata=in_data for exactly the next cycle (registered, latency 1).
- Otherwise we=0, and waddr/wdata hold their last values.
REQ-009 On each accepted word, csum SHALL be updated to csum XOR in_data, registered on the same edge as the accept.
REQ-010 On accepting word len-1, the FSM SHALL enter DONE on that same edge, so in_ready=0 in the following cycle.
- When len=32, the last address is 31; the counter SHALL NOT wrap or issue a 33rd write.
REQ-011 In DONE, the block SHALL hold done=1 and cpu_ce=1; in IDLE and LOAD, cpu_ce=0.
REQ-012 cpu_rst SHALL be 1 for exactly the first cycle in DONE; it coincides with the final we pulse.
REQ-013 busy SHALL be 1 exactly when the state is LOAD.
REQ-014 If start is accepted in DONE, cpu_ce SHALL drop to 0 on the next cycle and a fresh load begins at waddr=0.
REQ-015 If in_valid stays low, the block SHALL wait in LOAD indefinitely; there is no timeout.
REQ-016 Back-to-back accepts, one per cycle, SHALL be sustained at full rate.

Reset
REQ-017 While reset=0, the block SHALL force state=IDLE and hold all outputs as follows:
- in_ready=0, we=0, waddr=0, wdata=0;
- cpu_ce=0, cpu_rst=0, busy=0, done=0, err=0, csum=0;
- counter and latched len cleared.
REQ-018 Reset asserted mid-LOAD SHALL abort the load with no further we pulses.
- Memory words already written are not undone.
- done stays 0 until a later load completes.
REQ-019 After reset deasserts, the block SHALL wait in IDLE for a start request.

Verification
REQ-020 Basic load:
- Stimulus: start with len=3, then words 0x0001, 0x0A5A, 0x1FFF sent back-to-back.
- Response: we pulses at waddr 0,1,2 with matching wdata; done=1, cpu_ce=1, cpu_rst for one cycle; csum=0x15A4.
REQ-021 Bad length:
- Stimulus: start with len=0, then separately start with len=33.
- Response: err=1, state stays IDLE, in_ready=0, no we pulse.
REQ-022 Throttled source:
- Stimulus: len=2 with in_valid toggling 1,0,0,1.
- Response: exactly two writes (waddr 0 and 1), each one cycle after its accept; stalled cycles produce no we.
REQ-023 Full depth:
- Stimulus: len=32 with words equal to their index.
- Response: last write at waddr=31; in_ready=0 after it; no 33rd we even if in_valid stays 1.
REQ-024 Reset mid-load:
- Stimulus: len=8; assert reset after 4 accepts, release, then start len=1 with word 0x0123.
- Response: all outputs at reset values immediately; then a single write at waddr=0 with wdata=0x0123; csum=0x0123; done=1.
REQ-025 Reload from DONE:
- Stimulus: after a completed load, start with len=2.
- Response: cpu_ce=0 during the reload, restart at waddr=0, csum recomputed from 0; start pulses during LOAD are ignored.
